overdrive_unclamp: RTL and testbench

Iterative inverse of the cubic overdrive soft-clip curve. Accepts a clipped sample `y` in signed Q(FRAC_BITS) and returns the pre-clip value `x` that the overdrive curve maps to `y`. It sits in the analysis/cancellation path of the effects chain, where the dry signal is reconstructed from a clipped stream. A bit-serial bisection search evaluates the forward curve once per cycle, behind a valid/ready handshake on both sides.

---
 rtl/overdrive_unclamp_if.sv | 43 ++++
 rtl/overdrive_unclamp.sv | 149 ++++++++++++++
 tb/tb_overdrive_unclamp.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/overdrive_unclamp_if.sv
`default_nettype none
// overdrive_unclamp_if: valid/ready sample-in and result-out channels.
// out_sat exists only when OVERDRIVE_UNCLAMP_SAT_FLAG_EN is defined.
interface overdrive_unclamp_if #(
  parameter int DATA_W = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
  logic                     out_sat;
`endif

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
    ,
    input  out_sat
`endif
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
    ,
    output out_sat
`endif
  );
endinterface
`default_nettype wire

// File: rtl/overdrive_unclamp.sv
`default_nettype none
// ==========================================================================
// Module  : overdrive_unclamp
// Purpose : bit-serial bisection inverse of the cubic overdrive soft-clip.
//           Optional saturation flag: OVERDRIVE_UNCLAMP_SAT_FLAG_EN.
// Revision: 1.0
// ==========================================================================
module overdrive_unclamp #(
  parameter int DATA_W    = 24,
  parameter int FRAC_BITS = 12
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  overdrive_unclamp_if.slave bus
);
  localparam int c_pw = 2 * FRAC_BITS + 1;
  localparam int c_cw = (c_pw > DATA_W) ? c_pw : DATA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic                  neg_q, neg_d;
  logic [FRAC_BITS-1:0]  m_q, m_d;
  logic [FRAC_BITS-1:0]  probe_q, probe_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
  logic                  out_sat_q, out_sat_d;
`endif

  logic [FRAC_BITS-1:0]  w_cand;
  logic [FRAC_BITS:0]    w_f_cand;
  logic [FRAC_BITS-1:0]  w_mag;
  logic [DATA_W-1:0]     w_mag_ext;
  logic [DATA_W-1:0]     w_result;

  function automatic logic [FRAC_BITS:0] f_curve(input logic [FRAC_BITS-1:0] m);
    logic [c_pw-1:0] mx, t1, t2;
    mx = c_pw'(m);
    t1 = (mx * mx) >> FRAC_BITS;
    t2 = (t1 * mx) >> FRAC_BITS;
    return (FRAC_BITS + 1)'((t2 + c_pw'(3) * mx) >> 2);
  endfunction

  assign w_cand    = m_q | probe_q;
  assign w_f_cand  = f_curve(w_cand);
  // m_q ends as the largest m with f(m) < a, so the answer is one above it;
  // an all-ones m_q means even f(One-1) fell short of a (saturation).
  assign w_mag     = (a_q == '0) ? '0 : ((&m_q) ? m_q : m_q + 1'b1);
  assign w_mag_ext = DATA_W'(w_mag);
  assign w_result  = neg_q ? -w_mag_ext : w_mag_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      neg_q       <= 1'b0;
      m_q         <= '0;
      probe_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
      out_sat_q   <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      neg_q       <= neg_d;
      m_q         <= m_d;
      probe_q     <= probe_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
      out_sat_q   <= out_sat_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    neg_d       = neg_q;
    m_d         = m_q;
    probe_d     = probe_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
    out_sat_d   = out_sat_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          neg_d   = bus.in_data[DATA_W-1];
          a_d     = bus.in_data;
          if (bus.in_data[DATA_W-1]) begin
            a_d = -bus.in_data;
          end
          m_d     = '0;
          probe_d = {1'b1, {(FRAC_BITS-1){1'b0}}};
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (c_cw'(w_f_cand) < c_cw'(a_q)) begin
          m_d = w_cand;
        end
        probe_d = probe_q >> 1;
        if (probe_q[0]) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = w_result;
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
          out_sat_d   = &m_q;
`endif
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
  assign bus.out_sat   = out_sat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_overdrive_unclamp.sv
`default_nettype none
// tb_overdrive_unclamp: vector table, scoreboard-checked sweep and
// hand-written latency, back-pressure, input-isolation and reset sequences.
module tb_overdrive_unclamp;
  localparam int DATA_W    = 24;
  localparam int FRAC_BITS = 12;
  localparam int ONE       = 4096;
  localparam int PERIOD    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  overdrive_unclamp_if #(.DATA_W(DATA_W)) bus ();

  overdrive_unclamp #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int y;
    int x;
    bit sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   ftab[ONE];
  int   fmax;
  time  last_hs;

  function automatic int ref_f(int m);
    int t1, t2;
    t1 = (m * m) / ONE;
    t2 = (t1 * m) / ONE;
    return (t2 + 3 * m) / 4;
  endfunction

  // Linear smallest-m search over the tabulated forward curve.
  function automatic exp_t model(int y);
    exp_t e;
    int a, m;
    e.y   = y;
    e.sat = 1'b0;
    a     = (y < 0) ? -y : y;
    if (a == 0) begin
      e.x = 0;
    end else if (a > fmax) begin
      e.x   = ONE - 1;
      e.sat = 1'b1;
    end else begin
      m = 0;
      while (m < ONE - 1 && ftab[m] < a) m++;
      e.x = m;
    end
    if (y < 0) e.x = -e.x;
    return e;
  endfunction

  function automatic int prop_ok(int y, int x);
    int a, m;
    a = (y < 0) ? -y : y;
    m = (x < 0) ? -x : x;
    if (m >= ONE) return 0;
    if (ftab[m] < a) return 0;
    if (m == 0) return (a == 0) ? 1 : 0;
    return (ftab[m-1] < a) ? 1 : 0;
  endfunction

  task automatic check(input string name, input integer act, input integer req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL spurious_out: got result %0d, required no result", bus.out_data);
      end else begin
        e = sb_q.pop_front();
        check("out_data", bus.out_data, e.x);
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
        check("out_sat", bus.out_sat, e.sat);
`endif
        if (!e.sat) check("inverse_bracket", prop_ok(e.y, bus.out_data), 1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the input handshake edge.
  task automatic send(input int y, input exp_t e, input bit expect_out);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(y);
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL in_handshake_timeout: in_ready %0d, required 1", bus.in_ready);
    end else if (expect_out) begin
      sb_q.push_back(e);
    end
    @(posedge clk);
    last_hs = $time;
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = DATA_W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #(PERIOD * 80000);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t vt[14];
    int   bnd[$];
    int   lat, bad, stable, seen;
    time  t0;

    for (int m = 0; m < ONE; m++) ftab[m] = ref_f(m);
    fmax = ftab[ONE-1];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
`ifdef OVERDRIVE_UNCLAMP_SAT_FLAG_EN
    check("reset_out_sat", bus.out_sat, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hand-derived vectors: {y, x, saturated}.
    vt[0]  = '{3, 4, 1'b0};
    vt[1]  = '{-3, -4, 1'b0};
    vt[2]  = '{4, 6, 1'b0};
    vt[3]  = '{0, 0, 1'b0};
    vt[4]  = '{1, 2, 1'b0};
    vt[5]  = '{-1, -2, 1'b0};
    vt[6]  = '{2, 3, 1'b0};
    vt[7]  = '{4094, 4095, 1'b0};
    vt[8]  = '{-4094, -4095, 1'b0};
    vt[9]  = '{4095, 4095, 1'b1};
    vt[10] = '{20000, 4095, 1'b1};
    vt[11] = '{-8388608, -4095, 1'b1};
    vt[12] = '{8388607, 4095, 1'b1};
    vt[13] = '{-20000, -4095, 1'b1};
    for (int i = 0; i < 14; i++) send(vt[i].y, vt[i], 1'b1);
    drain();

    // Latency and back-pressure.
    bus.out_ready = 1'b0;
    send(3, '{3, 4, 1'b0}, 1'b1);
    check("in_ready_after_accept", bus.in_ready, 0);
    lat = 0;
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      if (bus.in_ready) bad = 1;
    end
    check("latency_edges", lat, FRAC_BITS + 1);
    check("in_ready_low_in_search", bad, 0);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.out_data !== 24'sd4 || bus.in_ready) stable = 0;
    end
    check("backpressure_hold", stable, 1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_out_hs", bus.in_ready, 1);
    check("out_valid_after_out_hs", bus.out_valid, 0);
    drain();

    // Throughput with out_ready held high.
    send(100, model(100), 1'b1);
    t0 = last_hs;
    send(-100, model(-100), 1'b1);
    check("throughput_cycles", int'((last_hs - t0) / PERIOD), FRAC_BITS + 3);
    drain();

    // Input isolation: in_data churns (and in_valid toggles) during SEARCH.
    send(1234, model(1234), 1'b1);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
      bus.in_data  = DATA_W'($urandom);
      bus.in_valid = c[0];
    end
    bus.in_valid = 1'b0;
    drain();

    // Asynchronous reset at cycle 6 of SEARCH.
    send(777, model(777), 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    check("async_rst_out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("no_result_after_reset", seen, 0);
    check("in_ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Sweep against the reference model.
    for (int y = -4100; y <= 4100; y += 3) send(y, model(y), 1'b1);
    bnd = '{-4096, -4095, -4093, -4092, 4093, 4096, 4097, -2, 0, 3000, -3001, 2048};
    foreach (bnd[i]) send(bnd[i], model(bnd[i]), 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
